// File: rtl/regfile_mp_pkg.sv
// Shared constants and sequencer state type for the multi-port register file.
package regfile_mp_pkg;

  // Default geometry of the integer register file.
  localparam int unsigned RV_BIT_NUM   = 32;
  localparam int unsigned ADDR_BIT_NUM = 5;
  localparam int unsigned REG_DEPTH    = 32;

  // Zero-fill sequencer states.
  typedef enum logic {
    RfStClear = 1'b0,
    RfStReady = 1'b1
  } rf_seq_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset zero-fill sequencer: walks every entry once, then parks in READY until next reset.
module regfile_clear_seq
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned ADDR_W = ADDR_BIT_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  rf_seq_state_e     state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  // Next state: advance the clear pointer, leave CLEAR after the last entry.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      RfStClear: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RfStReady;
        end
      end
      RfStReady: ;
    endcase
  end

  // State and pointer registers; reset restarts the full clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RfStClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign init_busy_o = (state_q == RfStClear);
  assign clr_we_o    = (state_q == RfStClear);
  assign clr_addr_o  = clr_addr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two prioritised write ports,
// optional hardwired-zero r0 and a post-reset zero-fill.
// Build option: define REGFILE_BYPASS_EN for write-first forwarding on same-cycle
// read/write address matches; otherwise reads return pre-write contents.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = RV_BIT_NUM,
  parameter int unsigned DEPTH    = REG_DEPTH,
  parameter int unsigned ADDR_W   = ADDR_BIT_NUM,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_valid_o,
  input  logic                     wr0_en_i,
  input  logic [ADDR_W-1:0]        wr0_addr_i,
  input  logic [DATA_W-1:0]        wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [ADDR_W-1:0]        wr1_addr_i,
  input  logic [DATA_W-1:0]        wr1_data_i,
  output logic                     init_busy_o
);

  logic              init_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr0_ok, wr1_ok;

  logic [DATA_W-1:0] mem_q [DEPTH];

  regfile_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_busy_o (init_busy),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  assign init_busy_o = init_busy;

  // Writes are blocked during the clear and, with ZERO_REG, to r0.
  assign wr0_ok = wr0_en_i && !init_busy && !((ZERO_REG != 0) && (wr0_addr_i == '0));
  assign wr1_ok = wr1_en_i && !init_busy && !((ZERO_REG != 0) && (wr1_addr_i == '0));

  // Array update; wr1 is issued last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (wr0_ok) mem_q[wr0_addr_i] <= wr0_data_i;
      if (wr1_ok) mem_q[wr1_addr_i] <= wr1_data_i;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              ok;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_q;

    assign addr = rd_addr_i[i*ADDR_W +: ADDR_W];
    assign ok   = rd_en_i[i] && !init_busy;

    // Read value selection: array, optional forwarding, then the r0 override.
    always_comb begin
      rdata = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr1_ok && (wr1_addr_i == addr)) begin
        rdata = wr1_data_i;
      end else if (wr0_ok && (wr0_addr_i == addr)) begin
        rdata = wr0_data_i;
      end
`endif
      if ((ZERO_REG != 0) && (addr == '0)) begin
        rdata = '0;
      end
      data_d = ok ? rdata : data_q;
    end

    // Registered read port; data holds when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= ok;
      end
    end

    assign rd_data_o[i*DATA_W +: DATA_W] = data_q;
    assign rd_valid_o[i]                 = valid_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against a behavioural register-file model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int NR    = 2;
  localparam int ZR    = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NR-1:0]    rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic             wr0_en = 1'b0;
  logic [AW-1:0]    wr0_addr = '0;
  logic [DW-1:0]    wr0_data = '0;
  logic             wr1_en = 1'b0;
  logic [AW-1:0]    wr1_addr = '0;
  logic [DW-1:0]    wr1_data = '0;
  logic             init_busy;

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_data [NR];
  logic [NR-1:0] exp_valid;
  int            busy_left;
  int            n_tests = 0;
  int            n_fail = 0;

  regfile_mp #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (ZR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .wr0_en_i    (wr0_en),
    .wr0_addr_i  (wr0_addr),
    .wr0_data_i  (wr0_data),
    .wr1_en_i    (wr1_en),
    .wr1_addr_i  (wr1_addr),
    .wr1_data_i  (wr1_data),
    .init_busy_o (init_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    busy_left = DEPTH;
    exp_valid = '0;
    for (int i = 0; i < NR; i++) exp_data[i] = '0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
  endtask

  task automatic idle_inputs();
    rd_en  = '0;
    wr0_en = 1'b0;
    wr1_en = 1'b0;
  endtask

  // Predict the effect of the current inputs, then advance one clock.
  task automatic tick();
    logic          busy;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    if (!rst_n) begin
      model_reset();
    end else begin
      busy = (busy_left != 0);
      for (int i = 0; i < NR; i++) begin
        if (!busy && rd_en[i]) begin
          a = rd_addr[i*AW +: AW];
          v = ref_mem[a];
`ifdef REGFILE_BYPASS_EN
          if (wr1_en && wr1_addr == a) v = wr1_data;
          else if (wr0_en && wr0_addr == a) v = wr0_data;
`endif
          if (ZR != 0 && a == 0) v = '0;
          exp_data[i]  = v;
          exp_valid[i] = 1'b1;
        end else begin
          exp_valid[i] = 1'b0;
        end
      end
      if (!busy) begin
        if (wr0_en && !(ZR != 0 && wr0_addr == 0)) ref_mem[wr0_addr] = wr0_data;
        if (wr1_en && !(ZR != 0 && wr1_addr == 0)) ref_mem[wr1_addr] = wr1_data;
      end else begin
        busy_left--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int c = 0; c < 3; c++) tick();
    n_tests++;
    if (init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 1", init_busy);
    end
    n_tests++;
    if (rd_valid !== '0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", rd_valid);
    end
    n_tests++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", rd_data);
    end
    rst_n = 1'b1;
    cnt = 0;
    // Random traffic during the clear must be ignored.
    for (int c = 0; c < 40 && init_busy; c++) begin
      rd_en    = NR'($urandom);
      rd_addr  = (NR*AW)'($urandom);
      wr0_en   = 1'b1;
      wr0_addr = AW'($urandom);
      wr0_data = $urandom;
      wr1_en   = 1'b1;
      wr1_addr = AW'($urandom);
      wr1_data = $urandom;
      tick();
      cnt++;
      n_tests++;
      if (rd_valid !== '0) begin
        n_fail++;
        $display("FAIL clear_valid: cycle %0d got %b want 0", cnt, rd_valid);
      end
    end
    idle_inputs();
    n_tests++;
    if (cnt != DEPTH || init_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_len: got %0d cycles busy=%b want %0d busy=0", cnt, init_busy, DEPTH);
    end
    for (int a = 0; a < DEPTH; a += NR) begin
      rd_en = '1;
      for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'(a + i);
      tick();
      for (int i = 0; i < NR; i++) begin
        n_tests++;
        if (rd_data[i*DW +: DW] !== exp_data[i] || rd_valid[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_read a=%0d: got %h/%b want %h/1", a + i,
                   rd_data[i*DW +: DW], rd_valid[i], exp_data[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    rd_en[0] = 1'b1; rd_addr[0 +: AW] = 5;
    tick();
    n_tests++;
    if (rd_data[0 +: DW] !== 32'hDEADBEEF || rd_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_rw: got %h/%b want deadbeef/1", rd_data[0 +: DW], rd_valid[0]);
    end
    idle_inputs();
    tick();
    n_tests++;
    if (rd_data[0 +: DW] !== 32'hDEADBEEF || rd_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got %h/%b want deadbeef/0", rd_data[0 +: DW], rd_valid[0]);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 7; wr1_data = 32'h22;
    tick();
    idle_inputs();
    rd_en[1] = 1'b1; rd_addr[AW +: AW] = 7;
    tick();
    n_tests++;
    if (rd_data[DW +: DW] !== 32'h22 || rd_data[DW +: DW] !== exp_data[1]) begin
      n_fail++;
      $display("FAIL collision: got %h want 22", rd_data[DW +: DW]);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] want;
    want = (ZR != 0) ? 32'h0 : 32'hFFFFFFFF;
    idle_inputs();
    wr1_en = 1'b1; wr1_addr = 0; wr1_data = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    rd_en = '1; rd_addr[0 +: AW] = 0; rd_addr[AW +: AW] = 0;
    tick();
    for (int i = 0; i < NR; i++) begin
      n_tests++;
      if (rd_data[i*DW +: DW] !== want || rd_data[i*DW +: DW] !== exp_data[i]) begin
        n_fail++;
        $display("FAIL zero_reg port%0d: got %h want %h", i, rd_data[i*DW +: DW], want);
      end
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'hB;
`else
    want = 32'hA;
`endif
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = 9; wr0_data = 32'hA;
    tick();
    idle_inputs();
    wr1_en = 1'b1; wr1_addr = 9; wr1_data = 32'hB;
    rd_en[0] = 1'b1; rd_addr[0 +: AW] = 9;
    tick();
    n_tests++;
    if (rd_data[0 +: DW] !== want || rd_data[0 +: DW] !== exp_data[0]) begin
      n_fail++;
      $display("FAIL bypass_same: got %h want %h", rd_data[0 +: DW], want);
    end
    idle_inputs();
    rd_en[0] = 1'b1; rd_addr[0 +: AW] = 9;
    tick();
    n_tests++;
    if (rd_data[0 +: DW] !== 32'hB) begin
      n_fail++;
      $display("FAIL bypass_next: got %h want b", rd_data[0 +: DW]);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rd_en = NR'($urandom);
      for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      wr0_en   = ($urandom_range(0, 1) == 1);
      wr0_addr = AW'($urandom_range(0, 7));
      wr0_data = $urandom;
      wr1_en   = ($urandom_range(0, 2) == 0);
      wr1_addr = AW'($urandom_range(0, 7));
      wr1_data = $urandom;
      tick();
      for (int i = 0; i < NR; i++) begin
        n_tests++;
        if (rd_valid[i] !== exp_valid[i] || rd_data[i*DW +: DW] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL random c=%0d port%0d: got %h/%b want %h/%b", c, i,
                   rd_data[i*DW +: DW], rd_valid[i], exp_data[i], exp_valid[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int cnt;
    for (int pass = 0; pass < 2; pass++) begin
      idle_inputs();
      if (pass == 0) begin
        for (int c = 0; c < 10; c++) tick();
      end else begin
        // Populate a few entries and leave live read data on the ports.
        for (int a = 1; a < 6; a++) begin
          wr0_en = 1'b1; wr0_addr = AW'(a); wr0_data = $urandom | 32'h1;
          tick();
        end
        idle_inputs();
        rd_en = '1; rd_addr[0 +: AW] = 1; rd_addr[AW +: AW] = 2;
        tick();
        idle_inputs();
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (init_busy !== 1'b1 || rd_valid !== '0 || rd_data !== '0) begin
        n_fail++;
        $display("FAIL midreset%0d_async: got busy=%b valid=%b data=%h want 1/0/0",
                 pass, init_busy, rd_valid, rd_data);
      end
      tick();
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 40 && init_busy; c++) begin
        tick();
        cnt++;
      end
      n_tests++;
      if (cnt != DEPTH || init_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset%0d_len: got %0d cycles want %0d", pass, cnt, DEPTH);
      end
      for (int a = 0; a < DEPTH; a += NR) begin
        rd_en = '1;
        for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'(a + i);
        tick();
        for (int i = 0; i < NR; i++) begin
          n_tests++;
          if (rd_data[i*DW +: DW] !== '0 || rd_valid[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset%0d_read a=%0d: got %h/%b want 0/1", pass, a + i,
                     rd_data[i*DW +: DW], rd_valid[i]);
          end
        end
      end
      idle_inputs();
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_collision();
    test_zero_reg();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
